mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max WAIT cycles without DACK before abort (range 1..255).
REQ-002 SHALL have port CLK  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port RES  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports EX_MEM_inst/EX_MEM_pc/EX_MEM_alu/EX_MEM_rs2  in  32 each  execute-stage instruction, PC, ALU result or address, store data.
REQ-005 SHALL have ports EX_MEM_rd  in  5; EX_MEM_is_load, EX_MEM_is_store  in  1 each.
REQ-006 SHALL have data-bus ports DADDR out 32; DATAO out 32; BE out 4; RD out 1; WR out 1; DATAI in 32; DACK in 1 (access done this cycle).
REQ-007 SHALL have ports MEM_WB_inst out 32; MEM_WB_rd out 5; MEM_WB_data out 32; MEM_WB_we out 1 (writeback-stage register).
REQ-008 SHALL have ports HLT out 1 (pipeline stall request), BUSERR out 1, MISALIGN out 1 (one-cycle pulses).

Function
REQ-009 SHALL implement FSM IDLE, WAIT. IDLE with load/store pending drives RD or WR combinationally in the same cycle.
REQ-010 SHALL, in IDLE with DACK=1, complete access that cycle; DACK=0 SHALL move to WAIT with counter=1.
REQ-011 SHALL, in WAIT, hold DADDR/DATAO/BE/RD/WR stable, increment counter each cycle, and return to IDLE on DACK.
REQ-012 SHALL, in WAIT at counter==TIMEOUT without DACK, drop strobes, pulse BUSERR, write MEM_WB_we=0 and return to IDLE.
REQ-013 SHALL drive HLT = pending access AND NOT DACK, combinational; HLT=0 on timeout-abort cycle.
REQ-014 SHALL ignore all EX_MEM_* inputs while HLT=1; upstream holds them.
REQ-015 SHALL set DADDR = {EX_MEM_alu[31:2],2'b00}.
REQ-016 SHALL, on store, use funct3 000: BE=1<<a[1:0], DATAO=rs2[7:0]x4; 001: BE=0011<<a[1:0], DATAO=rs2[15:0]x2; 010: BE=1111, DATAO=rs2.
REQ-017 SHALL, on load, extract lane by a[1:0]: 000 sign-extended byte, 001 sign-extended half, 010 word, 100 zero-extended byte, 101 zero-extended half; other funct3 yields 0.
REQ-018 SHALL update MEM_WB_* on the completion edge: memory ops on DACK; non-memory ops on the next edge (1-cycle latency), MEM_WB_data=EX_MEM_alu.
REQ-019 SHALL use MEM_WB_data=EX_MEM_pc+4 for JAL/JALR.
REQ-020 SHALL set MEM_WB_we=1 only when rd!=0 and opcode is LUI, AUIPC, JAL, JALR, load, OP-IMM, OP or custom-0; stores, branches, SYS and inst=0 give 0.
REQ-021 SHALL register a bubble (inst=0, we=0) into MEM_WB while HLT=1.

Reset
REQ-022 SHALL, on RES=0 at a clock edge, set FSM=IDLE, counter=0, and all MEM_WB_* outputs, BUSERR and MISALIGN to 0.
REQ-023 SHALL force RD=WR=0 and HLT=0 combinationally while RES=0; a reset during WAIT abandons the access with no writeback.

Configuration
REQ-024 With MEM_MISALIGN_TRAP_EN defined, a half access with a[0]!=0 or a word access with a[1:0]!=0 SHALL issue no strobes, pulse MISALIGN, and write MEM_WB_we=0 after one cycle.
REQ-025 Without MEM_MISALIGN_TRAP_EN, MISALIGN SHALL be tied 0 and the access SHALL proceed at the aligned DADDR with the lane given by a[1:0].

Structure
REQ-026 SHALL take opcode constants (LUI..CUS), load/store funct3 codes and the FSM state encoding from shared package core_pkg.
REQ-027 SHALL place load lane extraction and extension in sub-module load_align (in: DATAI, funct3, a[1:0]; out: 32-bit result).

Verification
REQ-028 Test: LB at 0x1003, DATAI=0x80xxxxxx, DACK same cycle -> RD for 1 cycle, HLT=0, next edge MEM_WB_data=0xFFFFFF80, we=1.
REQ-029 Test: SH rs2=0x0000BEEF at 0x2002, DACK after 3 cycles -> BE=1100, DATAO=0xBEEFBEEF held 4 cycles, HLT=1 for 3 cycles, MEM_WB_we=0.
REQ-030 Test: LW with DACK never asserted, TIMEOUT=16 -> abort on 16th WAIT cycle, BUSERR pulses once, HLT falls, no writeback.
REQ-031 Test: ADDI rd=x0 then JAL rd=x1 at pc 0x80000010 -> we=0, then MEM_WB_data=0x80000014, we=1.
REQ-032 Test: LW at 0x3001 -> with macro: MISALIGN=1, no RD; without macro: RD at DADDR 0x3000.
REQ-033 Test: RES=0 in 2nd WAIT cycle -> RD drops immediately, outputs 0 next edge, FSM IDLE.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32 core constants: opcodes, load/store funct3 codes and the memory-stage FSM states.
package core_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;
    localparam logic [6:0] OPC_CUS    = 7'b0001011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Register-file write enable for an instruction retiring through MEM_WB
    function automatic logic writes_rd(input logic [31:0] inst, input logic [4:0] rd);
        logic hit;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OPIMM, OPC_OP, OPC_CUS: hit = 1'b1;
            default:                              hit = 1'b0;
        endcase
        return hit && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load lane extraction: selects the addressed byte/half/word of DATAI and sign/zero extends it.
module load_align
    import core_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] result_o
);

    logic [31:0] lane;

    assign lane = data_i >> {addr_lo_i, 3'b000};

    always_comb begin
        result_o = '0;
        case (funct3_i)
            F3_B:    result_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    result_o = {{16{lane[15]}}, lane[15:0]};
            F3_W:    result_o = lane;
            F3_BU:   result_o = {24'd0, lane[7:0]};
            F3_HU:   result_o = {16'd0, lane[15:0]};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory pipeline stage: drives the data bus for loads/stores, stalls on DACK with a timeout, fills MEM_WB.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are trapped instead of issued.
module mem_access
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] EX_MEM_inst,
    input  logic [31:0] EX_MEM_pc,
    input  logic [31:0] EX_MEM_alu,
    input  logic [31:0] EX_MEM_rs2,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_is_load,
    input  logic        EX_MEM_is_store,
    output logic [31:0] DADDR,
    output logic [31:0] DATAO,
    output logic [3:0]  BE,
    output logic        RD,
    output logic        WR,
    input  logic [31:0] DATAI,
    input  logic        DACK,
    output logic [31:0] MEM_WB_inst,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] MEM_WB_data,
    output logic        MEM_WB_we,
    output logic        HLT,
    output logic        BUSERR,
    output logic        MISALIGN
);

    mem_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] hold_inst_q, hold_alu_q, hold_rs2_q;
    logic [4:0]  hold_rd_q;
    logic        hold_load_q, hold_store_q;
    logic        hold_en;

    logic [31:0] wb_inst_q, wb_inst_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_we_q, wb_we_d;
    logic        buserr_q, buserr_d;

    logic [31:0] cur_inst, cur_alu, cur_rs2;
    logic [4:0]  cur_rd;
    logic        cur_load, cur_store;
    logic        in_wait;
    logic [2:0]  f3;
    logic [1:0]  a_lo;
    logic        mem_op, misaligned, access, timeout_hit, is_link;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_data;
    logic        done_we;
    logic [31:0] done_data;

    // While waiting, the bus and writeback use the snapshot, so upstream changes are ignored
    assign in_wait   = (state_q == ST_WAIT);
    assign cur_inst  = in_wait ? hold_inst_q  : EX_MEM_inst;
    assign cur_alu   = in_wait ? hold_alu_q   : EX_MEM_alu;
    assign cur_rs2   = in_wait ? hold_rs2_q   : EX_MEM_rs2;
    assign cur_rd    = in_wait ? hold_rd_q    : EX_MEM_rd;
    assign cur_load  = in_wait ? hold_load_q  : EX_MEM_is_load;
    assign cur_store = in_wait ? hold_store_q : EX_MEM_is_store;

    assign f3      = cur_inst[14:12];
    assign a_lo    = cur_alu[1:0];
    assign mem_op  = cur_load | cur_store;
    assign is_link = (cur_inst[6:0] == OPC_JAL) || (cur_inst[6:0] == OPC_JALR);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = mem_op && (((f3[1:0] == 2'b01) && a_lo[0]) ||
                                   ((f3[1:0] == 2'b10) && (a_lo != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign timeout_hit = in_wait && (cnt_q == 8'(TIMEOUT)) && !DACK;
    assign access      = RES && mem_op && !misaligned && !timeout_hit;

    assign RD    = access && cur_load;
    assign WR    = access && cur_store;
    assign HLT   = access && !DACK;
    assign DADDR = {cur_alu[31:2], 2'b00};
    assign BE    = be_c;
    assign DATAO = wdata_c;

    always_comb begin
        be_c    = '0;
        wdata_c = cur_rs2;
        case (f3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << a_lo;
                wdata_c = {4{cur_rs2[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << a_lo;
                wdata_c = {2{cur_rs2[15:0]}};
            end
            2'b10:   be_c = 4'b1111;
            default: be_c = '0;
        endcase
    end

    load_align u_load_align (
        .data_i    (DATAI),
        .funct3_i  (f3),
        .addr_lo_i (a_lo),
        .result_o  (load_data)
    );

    assign done_we   = writes_rd(cur_inst, cur_rd) && !misaligned;
    assign done_data = cur_load ? load_data : (is_link ? EX_MEM_pc + 32'd4 : cur_alu);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_en   = 1'b0;
        wb_inst_d = '0;
        wb_rd_d   = '0;
        wb_data_d = '0;
        wb_we_d   = 1'b0;
        buserr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access && !DACK) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd1;
                    hold_en = 1'b1;
                end else begin
                    wb_inst_d = cur_inst;
                    wb_rd_d   = cur_rd;
                    wb_data_d = done_data;
                    wb_we_d   = done_we;
                end
            end
            ST_WAIT: begin
                if (DACK) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    wb_inst_d = cur_inst;
                    wb_rd_d   = cur_rd;
                    wb_data_d = done_data;
                    wb_we_d   = done_we;
                end else if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    buserr_d  = 1'b1;
                    wb_inst_d = cur_inst;
                    wb_rd_d   = cur_rd;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RES) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wb_inst_q <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
            buserr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_inst_q <= wb_inst_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_we_q   <= wb_we_d;
            buserr_q  <= buserr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (hold_en) begin
            hold_inst_q  <= EX_MEM_inst;
            hold_alu_q   <= EX_MEM_alu;
            hold_rs2_q   <= EX_MEM_rs2;
            hold_rd_q    <= EX_MEM_rd;
            hold_load_q  <= EX_MEM_is_load;
            hold_store_q <= EX_MEM_is_store;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge CLK) begin
        if (!RES) mis_q <= 1'b0;
        else      mis_q <= misaligned;
    end

    assign MISALIGN = mis_q;
`else
    assign MISALIGN = 1'b0;
`endif

    assign MEM_WB_inst = wb_inst_q;
    assign MEM_WB_rd   = wb_rd_q;
    assign MEM_WB_data = wb_data_q;
    assign MEM_WB_we   = wb_we_q;
    assign BUSERR      = buserr_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized traffic against a behavioural model.
// Honours MEM_MISALIGN_TRAP_EN the same way as the design build.
module tb_mem_access;

    localparam int unsigned TO = 16;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
    localparam logic [6:0] BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23;
    localparam logic [6:0] OPIMM = 7'h13, OP = 7'h33, SYS = 7'h73, CUS = 7'h0B;
    localparam logic [6:0] ALU_OPS [8] = '{LUI, AUIPC, OPIMM, OP, CUS, BRANCH, SYS, 7'h00};
    localparam logic [2:0] LD_F3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    logic        CLK = 1'b0;
    logic        RES;
    logic [31:0] EX_MEM_inst, EX_MEM_pc, EX_MEM_alu, EX_MEM_rs2;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_is_load, EX_MEM_is_store;
    logic [31:0] DADDR, DATAO, DATAI;
    logic [3:0]  BE;
    logic        RD, WR, DACK;
    logic [31:0] MEM_WB_inst, MEM_WB_data;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_we, HLT, BUSERR, MISALIGN;

    int checks = 0;
    int errors = 0;

    mem_access #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RES(RES),
        .EX_MEM_inst(EX_MEM_inst), .EX_MEM_pc(EX_MEM_pc), .EX_MEM_alu(EX_MEM_alu),
        .EX_MEM_rs2(EX_MEM_rs2), .EX_MEM_rd(EX_MEM_rd),
        .EX_MEM_is_load(EX_MEM_is_load), .EX_MEM_is_store(EX_MEM_is_store),
        .DADDR(DADDR), .DATAO(DATAO), .BE(BE), .RD(RD), .WR(WR),
        .DATAI(DATAI), .DACK(DACK),
        .MEM_WB_inst(MEM_WB_inst), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_data(MEM_WB_data),
        .MEM_WB_we(MEM_WB_we), .HLT(HLT), .BUSERR(BUSERR), .MISALIGN(MISALIGN)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    function automatic logic [31:0] make_inst(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [4:0] rd);
        logic [31:0] r;
        r = $urandom;
        return {r[31:15], f3, rd, op};
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic ld,
                         input logic st);
        EX_MEM_inst = inst; EX_MEM_pc = pc; EX_MEM_alu = alu; EX_MEM_rs2 = rs2;
        EX_MEM_rd = rd; EX_MEM_is_load = ld; EX_MEM_is_store = st;
    endtask

    task automatic drive_nop();
        drive('0, '0, '0, '0, '0, 1'b0, 1'b0);
        DACK = 1'b0;
    endtask

    // Reference model: writeback enable, load result, store byte enables and store data
    function automatic logic model_we(input logic [31:0] inst, input logic [4:0] rd);
        if (rd == 5'd0) return 1'b0;
        return inst[6:0] inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, CUS};
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] a);
        logic [31:0] v, b, h;
        v = w >> (8 * a);
        b = v % 256;
        h = v % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd2:    return v;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'd0) return 4'(1 << a);
        if (f3 == 3'd1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        if (f3 == 3'd0) return (rs2 % 256) * 32'h0101_0101;
        if (f3 == 3'd1) return (rs2 % 65536) * 32'h0001_0001;
        return rs2;
    endfunction

    task automatic test_reset();
        RES = 1'b0;
        drive(make_inst(LOAD, 3'd2, 5'd3), 32'h0, 32'h100, 32'h0, 5'd3, 1'b1, 1'b0);
        DACK = 1'b0;
        settle();
        checks++;
        if ({RD, WR, HLT} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 000", {RD, WR, HLT});
        end
        tick();
        tick();
        checks++;
        if ({MEM_WB_inst, MEM_WB_rd, MEM_WB_data, MEM_WB_we, BUSERR, MISALIGN} !== '0) begin
            errors++; $display("FAIL reset_regs: got inst=%h rd=%0d data=%h we=%b be=%b mis=%b expected all 0",
                               MEM_WB_inst, MEM_WB_rd, MEM_WB_data, MEM_WB_we, BUSERR, MISALIGN);
        end
        RES = 1'b1;
        drive_nop();
        tick();
    endtask

    task automatic test_lb_same_cycle();
        drive(make_inst(LOAD, 3'd0, 5'd7), 32'h400, 32'h1003, 32'h0, 5'd7, 1'b1, 1'b0);
        DATAI = 32'h8012_3456;
        DACK  = 1'b1;
        settle();
        checks++;
        if ({RD, WR, HLT, DADDR} !== {3'b100, 32'h1000}) begin
            errors++; $display("FAIL lb_bus: got rd/wr/hlt=%b daddr=%h expected 100 00001000",
                               {RD, WR, HLT}, DADDR);
        end
        tick();
        checks++;
        if ({MEM_WB_data, MEM_WB_we, MEM_WB_rd} !== {32'hFFFF_FF80, 1'b1, 5'd7}) begin
            errors++; $display("FAIL lb_wb: got data=%h we=%b rd=%0d expected ffffff80 1 7",
                               MEM_WB_data, MEM_WB_we, MEM_WB_rd);
        end
        drive_nop();
        settle();
        checks++;
        if (RD !== 1'b0) begin
            errors++; $display("FAIL lb_rd_one_cycle: got RD=%b expected 0", RD);
        end
        tick();
    endtask

    task automatic test_sh_wait();
        logic [31:0] inst;
        logic        exp_h;
        inst = make_inst(STORE, 3'd1, 5'd0);
        drive(inst, 32'h500, 32'h2002, 32'h0000_BEEF, 5'd0, 1'b0, 1'b1);
        for (int unsigned c = 0; c < 4; c++) begin
            DACK  = (c == 3);
            exp_h = (c < 3);
            settle();
            checks++;
            if ({WR, RD, HLT, BE, DATAO, DADDR} !== {1'b1, 1'b0, exp_h, 4'b1100, 32'hBEEF_BEEF, 32'h2000}) begin
                errors++; $display("FAIL sh_bus c=%0d: got wr/rd/hlt=%b be=%b datao=%h daddr=%h expected %b 1100 beefbeef 00002000",
                                   c, {WR, RD, HLT}, BE, DATAO, DADDR, {2'b10, exp_h});
            end
            tick();
            checks++;
            if ({MEM_WB_inst, MEM_WB_we} !== {((c < 3) ? 32'h0 : inst), 1'b0}) begin
                errors++; $display("FAIL sh_wb c=%0d: got inst=%h we=%b expected inst=%h we=0",
                                   c, MEM_WB_inst, MEM_WB_we, (c < 3) ? 32'h0 : inst);
            end
        end
        drive_nop();
        tick();
    endtask

    task automatic test_timeout();
        logic exp_a;
        drive(make_inst(LOAD, 3'd2, 5'd9), 32'h600, 32'h4000, 32'h0, 5'd9, 1'b1, 1'b0);
        DACK = 1'b0;
        for (int unsigned c = 0; c <= TO; c++) begin
            exp_a = (c < TO);
            settle();
            checks++;
            if ({RD, HLT} !== {exp_a, exp_a}) begin
                errors++; $display("FAIL timeout_strobe c=%0d: got rd/hlt=%b expected %b",
                                   c, {RD, HLT}, {exp_a, exp_a});
            end
            tick();
            if (c == TO) drive_nop();
            checks++;
            if ({BUSERR, MEM_WB_we} !== {(c == TO), 1'b0}) begin
                errors++; $display("FAIL timeout_buserr c=%0d: got buserr/we=%b expected %b0",
                                   c, {BUSERR, MEM_WB_we}, (c == TO));
            end
        end
        tick();
        checks++;
        if (BUSERR !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse: got BUSERR=%b expected 0", BUSERR);
        end
    endtask

    task automatic test_alu_jal();
        logic [31:0] inst;
        inst = make_inst(OPIMM, 3'd0, 5'd0);
        drive(inst, 32'h700, 32'h55, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if ({MEM_WB_inst, MEM_WB_data, MEM_WB_we} !== {inst, 32'h55, 1'b0}) begin
            errors++; $display("FAIL addi_x0: got inst=%h data=%h we=%b expected %h 00000055 0",
                               MEM_WB_inst, MEM_WB_data, MEM_WB_we, inst);
        end
        inst = make_inst(JAL, 3'd0, 5'd1);
        drive(inst, 32'h8000_0010, 32'h1234_0000, 32'h0, 5'd1, 1'b0, 1'b0);
        tick();
        checks++;
        if ({MEM_WB_data, MEM_WB_we, MEM_WB_rd} !== {32'h8000_0014, 1'b1, 5'd1}) begin
            errors++; $display("FAIL jal_link: got data=%h we=%b rd=%0d expected 80000014 1 1",
                               MEM_WB_data, MEM_WB_we, MEM_WB_rd);
        end
        drive_nop();
        tick();
    endtask

    task automatic test_misalign();
        drive(make_inst(LOAD, 3'd2, 5'd4), 32'h800, 32'h3001, 32'h0, 5'd4, 1'b1, 1'b0);
        DATAI = $urandom;
        DACK  = 1'b1;
        settle();
`ifdef MEM_MISALIGN_TRAP_EN
        checks++;
        if ({RD, HLT} !== 2'b00) begin
            errors++; $display("FAIL misalign_strobe: got rd/hlt=%b expected 00", {RD, HLT});
        end
        tick();
        drive_nop();
        checks++;
        if ({MISALIGN, MEM_WB_we} !== 2'b10) begin
            errors++; $display("FAIL misalign_trap: got mis/we=%b expected 10", {MISALIGN, MEM_WB_we});
        end
        tick();
        checks++;
        if (MISALIGN !== 1'b0) begin
            errors++; $display("FAIL misalign_pulse: got MISALIGN=%b expected 0", MISALIGN);
        end
`else
        checks++;
        if ({RD, HLT, DADDR} !== {2'b10, 32'h3000}) begin
            errors++; $display("FAIL misalign_bus: got rd/hlt=%b daddr=%h expected 10 00003000",
                               {RD, HLT}, DADDR);
        end
        tick();
        drive_nop();
        checks++;
        if ({MISALIGN, MEM_WB_we, MEM_WB_data} !== {2'b01, model_load(DATAI, 3'd2, 2'd1)}) begin
            errors++; $display("FAIL misalign_wb: got mis=%b we=%b data=%h expected 0 1 %h",
                               MISALIGN, MEM_WB_we, MEM_WB_data, model_load(DATAI, 3'd2, 2'd1));
        end
        tick();
`endif
    endtask

    task automatic test_reset_in_wait();
        drive(make_inst(LOAD, 3'd2, 5'd6), 32'h900, 32'h5000, 32'h0, 5'd6, 1'b1, 1'b0);
        DACK = 1'b0;
        tick();
        tick();
        settle();
        checks++;
        if ({RD, HLT} !== 2'b11) begin
            errors++; $display("FAIL rstwait_before: got rd/hlt=%b expected 11", {RD, HLT});
        end
        RES = 1'b0;
        #1;
        checks++;
        if ({RD, WR, HLT} !== 3'b000) begin
            errors++; $display("FAIL rstwait_drop: got rd/wr/hlt=%b expected 000", {RD, WR, HLT});
        end
        tick();
        checks++;
        if ({MEM_WB_inst, MEM_WB_rd, MEM_WB_data, MEM_WB_we, BUSERR} !== '0) begin
            errors++; $display("FAIL rstwait_regs: got inst=%h rd=%0d data=%h we=%b buserr=%b expected all 0",
                               MEM_WB_inst, MEM_WB_rd, MEM_WB_data, MEM_WB_we, BUSERR);
        end
        RES = 1'b1;
        drive(make_inst(OPIMM, 3'd0, 5'd5), 32'hA00, 32'h1234_5678, 32'h0, 5'd5, 1'b0, 1'b0);
        settle();
        checks++;
        if ({RD, HLT} !== 2'b00) begin
            errors++; $display("FAIL rstwait_idle: got rd/hlt=%b expected 00", {RD, HLT});
        end
        tick();
        checks++;
        if ({MEM_WB_data, MEM_WB_we} !== {32'h1234_5678, 1'b1}) begin
            errors++; $display("FAIL rstwait_next: got data=%h we=%b expected 12345678 1",
                               MEM_WB_data, MEM_WB_we);
        end
        drive_nop();
        tick();
    endtask

    task automatic test_random();
        logic [31:0] inst, pc, alu, rs2, exp_data;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        ld, st, exp_h;
        int unsigned kind, lat;
        for (int unsigned n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            rd   = 5'($urandom);
            pc   = $urandom & 32'hFFFF_FFFC;
            alu  = $urandom;
            rs2  = $urandom;
            ld   = (kind == 2);
            st   = (kind == 3);
            f3   = 3'($urandom);
            case (kind)
                0:       op = ALU_OPS[$urandom_range(0, 7)];
                1:       op = ($urandom_range(0, 1) == 0) ? JAL : JALR;
                2:       begin op = LOAD;  f3 = LD_F3[$urandom_range(0, 4)]; end
                default: begin op = STORE; f3 = 3'($urandom_range(0, 2)); end
            endcase
            if (ld || st) alu = alu & ~((32'd1 << f3[1:0]) - 32'd1);
            inst = make_inst(op, f3, rd);
            drive(inst, pc, alu, rs2, rd, ld, st);
            DATAI = $urandom;
            if (ld || st) begin
                lat = $urandom_range(0, 3);
                for (int unsigned c = 0; c <= lat; c++) begin
                    DACK  = (c == lat);
                    exp_h = (c < lat);
                    settle();
                    checks++;
                    if ({RD, WR, HLT, DADDR} !== {ld, st, exp_h, alu[31:2], 2'b00}) begin
                        errors++; $display("FAIL rnd_bus n=%0d c=%0d: got rd/wr/hlt=%b daddr=%h expected %b %h",
                                           n, c, {RD, WR, HLT}, DADDR, {ld, st, exp_h}, {alu[31:2], 2'b00});
                    end
                    if (st) begin
                        checks++;
                        if ({BE, DATAO} !== {model_be(f3, alu[1:0]), model_wdata(f3, rs2)}) begin
                            errors++; $display("FAIL rnd_store n=%0d: got be=%b datao=%h expected %b %h",
                                               n, BE, DATAO, model_be(f3, alu[1:0]), model_wdata(f3, rs2));
                        end
                    end
                    tick();
                    if (c < lat) begin
                        EX_MEM_alu = $urandom;
                        EX_MEM_rs2 = $urandom;
                        checks++;
                        if ({MEM_WB_inst, MEM_WB_we} !== 33'd0) begin
                            errors++; $display("FAIL rnd_bubble n=%0d: got inst=%h we=%b expected 0 0",
                                               n, MEM_WB_inst, MEM_WB_we);
                        end
                    end
                end
                exp_data = ld ? model_load(DATAI, f3, alu[1:0]) : MEM_WB_data;
            end else begin
                DACK = 1'b0;
                settle();
                checks++;
                if ({RD, WR, HLT} !== 3'b000) begin
                    errors++; $display("FAIL rnd_nomem n=%0d: got rd/wr/hlt=%b expected 000", n, {RD, WR, HLT});
                end
                tick();
                exp_data = (op == JAL || op == JALR) ? pc + 32'd4 : alu;
            end
            checks++;
            if ({MEM_WB_inst, MEM_WB_rd, MEM_WB_data, MEM_WB_we} !== {inst, rd, exp_data, model_we(inst, rd)}) begin
                errors++; $display("FAIL rnd_wb n=%0d: got inst=%h rd=%0d data=%h we=%b expected %h %0d %h %b",
                                   n, MEM_WB_inst, MEM_WB_rd, MEM_WB_data, MEM_WB_we,
                                   inst, rd, exp_data, model_we(inst, rd));
            end
        end
        drive_nop();
        tick();
    endtask

    initial begin
        RES   = 1'b0;
        DATAI = '0;
        drive_nop();
        test_reset();
        test_lb_same_cycle();
        test_sh_wait();
        test_timeout();
        test_alu_jal();
        test_misalign();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
